// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: N-way input side, single output side,
// plus flush and the sticky select-error flag.
interface mux_n_pipe_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
);
    logic                      flush;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sel_err;

    modport master (
        output flush, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport slave (
        input  flush, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input select stage with a registered output, a 2-entry skid buffer
// (main + skid) and a registered in_ready, so full throughput is kept
// without any combinational path from out_ready to in_ready.
module mux_n_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic         clk,
    input  logic         rst,
    mux_n_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     main_data_q, main_data_d;
    logic [SEL_W-1:0]     main_sel_q,  main_sel_d;
    logic [WIDTH-1:0]     skid_data_q, skid_data_d;
    logic [SEL_W-1:0]     skid_sel_q,  skid_sel_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sel_err_q,   sel_err_d;

    logic [WIDTH-1:0]     sel_word_c;
    logic                 sel_oor_c;
    logic                 in_xfer_c;
    logic                 out_xfer_c;

    // Out-of-range selects match no lane and therefore yield all zeros.
    always_comb begin
        sel_word_c = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_word_c = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
        sel_oor_c = 32'(bus.in_sel) >= NUM_IN;
    end

    assign in_xfer_c  = bus.in_valid & in_ready_q;
    assign out_xfer_c = out_valid_q & bus.out_ready;

    // Occupancy FSM; in_ready/out_valid are registered functions of next state.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        sel_err_d   = sel_err_q;

        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            if (in_xfer_c && sel_oor_c) begin
                sel_err_d = 1'b1;
            end
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_c) begin
                        main_data_d = sel_word_c;
                        main_sel_d  = bus.in_sel;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_c && out_xfer_c) begin
                        main_data_d = sel_word_c;
                        main_sel_d  = bus.in_sel;
                    end else if (in_xfer_c) begin
                        skid_data_d = sel_word_c;
                        skid_sel_d  = bus.in_sel;
                        state_d     = ST_FULL;
                    end else if (out_xfer_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_c) begin
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_sel   = main_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: a 4-input instance driven from a vector
// table and a 3-input instance driven by hand for select-error/reset cases.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_n_pipe_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) b4 ();
    mux_n_pipe_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) b3 ();

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (.clk(clk), .rst(rst), .bus(b4));
    mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] w;
        logic        ordy;
        logic        fl;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [1:0]  exp_os;
        logic        exp_ir;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] L0 = 32'h0A0A_0A00;
    localparam logic [31:0] L1 = 32'h1B1B_1B11;
    localparam logic [31:0] L2 = 32'h2C2C_2C22;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, input logic [1:0] sel, input logic [31:0] w,
                                input logic ordy, input logic fl, input logic eov,
                                input logic [31:0] eod, input logic [1:0] eos, input logic eir);
        vec_t t;
        t.v = v; t.sel = sel; t.w = w; t.ordy = ordy; t.fl = fl;
        t.exp_ov = eov; t.exp_od = eod; t.exp_os = eos; t.exp_ir = eir;
        vecs.push_back(t);
    endfunction

    // Selected lane carries w; the others carry distinct decoys.
    function automatic logic [127:0] mk(input logic [1:0] sel, input logic [31:0] w);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) begin
            d[k*32 +: 32] = (2'(k) == sel) ? w : (~w ^ 32'(k + 1));
        end
        return d;
    endfunction

    task automatic step3(input logic r, input logic v, input logic [1:0] sel,
                         input logic ordy, input logic fl);
        rst          = r;
        b3.in_valid  = v;
        b3.in_sel    = sel;
        b3.out_ready = ordy;
        b3.flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        b4.in_valid = 1'b0; b4.in_sel = '0; b4.in_data = '0; b4.out_ready = 1'b1; b4.flush = 1'b0;
        b3.in_valid = 1'b0; b3.in_sel = '0; b3.in_data = {L2, L1, L0}; b3.out_ready = 1'b1; b3.flush = 1'b0;

        // select each input in turn at full rate
        add(1, 2'd0, 32'h1111_1111, 1, 0, 1, 32'h1111_1111, 2'd0, 1);
        add(1, 2'd1, 32'h2222_2222, 1, 0, 1, 32'h2222_2222, 2'd1, 1);
        add(1, 2'd2, 32'h3333_3333, 1, 0, 1, 32'h3333_3333, 2'd2, 1);
        add(1, 2'd3, 32'h4444_4444, 1, 0, 1, 32'h4444_4444, 2'd3, 1);
        add(0, 2'd0, 32'h0,         1, 0, 0, 32'h4444_4444, 2'd3, 1);
        // backpressure: A main, B skid, C held off, then drain in order
        add(1, 2'd1, 32'hA, 0, 0, 1, 32'hA, 2'd1, 1);
        add(1, 2'd2, 32'hB, 0, 0, 1, 32'hA, 2'd1, 0);
        add(1, 2'd3, 32'hC, 0, 0, 1, 32'hA, 2'd1, 0);
        add(1, 2'd3, 32'hC, 1, 0, 1, 32'hB, 2'd2, 1);
        add(1, 2'd3, 32'hC, 1, 0, 1, 32'hC, 2'd3, 1);
        add(0, 2'd0, 32'h0, 1, 0, 0, 32'hC, 2'd3, 1);
        // simultaneous transfers in ONE
        for (int i = 0; i < 8; i++) begin
            add(1, 2'(i % 4), 32'h5A00_0000 + 32'(i), 1, 0, 1, 32'h5A00_0000 + 32'(i), 2'(i % 4), 1);
        end
        add(0, 2'd0, 32'h0, 1, 0, 0, 32'h5A00_0007, 2'd3, 1);
        // flush while FULL, then flush in ONE with an input offered
        add(1, 2'd0, 32'hD0, 0, 0, 1, 32'hD0, 2'd0, 1);
        add(1, 2'd1, 32'hE0, 0, 0, 1, 32'hD0, 2'd0, 0);
        add(1, 2'd2, 32'hF0, 0, 1, 0, 32'hD0, 2'd0, 1);
        add(1, 2'd3, 32'h60, 0, 0, 1, 32'h60, 2'd3, 1);
        add(1, 2'd1, 32'h61, 0, 1, 0, 32'h60, 2'd3, 1);
        add(1, 2'd2, 32'h62, 1, 0, 1, 32'h62, 2'd2, 1);
        add(0, 2'd0, 32'h0,  1, 0, 0, 32'h62, 2'd2, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_in_ready",  32'(b4.in_ready),  32'd1);
        chk("rst_out_data",  b4.out_data,       32'd0);
        chk("rst_out_sel",   32'(b4.out_sel),   32'd0);
        chk("rst_sel_err",   32'(b4.sel_err),   32'd0);

        foreach (vecs[i]) begin
            b4.in_valid  = vecs[i].v;
            b4.in_sel    = vecs[i].sel;
            b4.in_data   = mk(vecs[i].sel, vecs[i].w);
            b4.out_ready = vecs[i].ordy;
            b4.flush     = vecs[i].fl;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), 32'(b4.out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_out_data",  i), b4.out_data,       vecs[i].exp_od);
            chk($sformatf("v%0d_out_sel",   i), 32'(b4.out_sel),   32'(vecs[i].exp_os));
            chk($sformatf("v%0d_in_ready",  i), 32'(b4.in_ready),  32'(vecs[i].exp_ir));
            chk($sformatf("v%0d_sel_err",   i), 32'(b4.sel_err),   32'd0);
        end
        b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b1;

        // out-of-range select offered during flush must not set sel_err
        step3(0, 1, 2'd3, 1, 1);
        chk("fl_oor_out_valid", 32'(b3.out_valid), 32'd0);
        chk("fl_oor_sel_err",   32'(b3.sel_err),   32'd0);
        step3(0, 1, 2'd3, 1, 0);
        chk("oor_out_valid", 32'(b3.out_valid), 32'd1);
        chk("oor_out_data",  b3.out_data,       32'd0);
        chk("oor_out_sel",   32'(b3.out_sel),   32'd3);
        chk("oor_sel_err",   32'(b3.sel_err),   32'd1);
        step3(0, 1, 2'd1, 1, 0);
        chk("legal_out_data", b3.out_data,     L1);
        chk("legal_sel_err",  32'(b3.sel_err), 32'd1);
        step3(0, 0, 2'd0, 1, 0);
        chk("idle_out_valid", 32'(b3.out_valid), 32'd0);
        chk("idle_sel_err",   32'(b3.sel_err),   32'd1);
        step3(0, 1, 2'd0, 0, 0);
        chk("fill_out_data", b3.out_data, L0);
        step3(0, 1, 2'd2, 0, 0);
        chk("full_in_ready", 32'(b3.in_ready),  32'd0);
        chk("full_out_data", b3.out_data,       L0);
        // rst and flush together while FULL
        step3(1, 1, 2'd1, 1, 1);
        chk("rst2_out_valid", 32'(b3.out_valid), 32'd0);
        chk("rst2_in_ready",  32'(b3.in_ready),  32'd1);
        chk("rst2_out_data",  b3.out_data,       32'd0);
        chk("rst2_out_sel",   32'(b3.out_sel),   32'd0);
        chk("rst2_sel_err",   32'(b3.sel_err),   32'd0);
        chk("rst2_u4_out_data", b4.out_data,     32'd0);
        step3(0, 1, 2'd2, 1, 0);
        chk("post_rst_out_valid", 32'(b3.out_valid), 32'd1);
        chk("post_rst_out_data",  b3.out_data,       L2);
        chk("post_rst_out_sel",   32'(b3.out_sel),   32'd2);
        step3(0, 0, 2'd0, 1, 0);
        chk("post_rst_drain", 32'(b3.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
